// File: rtl/adapter_pkg.sv
// Shared constants and sizing helpers for the bus-word register adapters
// (serialising output register and reassembling input register).
package adapter_pkg;

  localparam int ADAPTER_WORD_W = 32;

  // Number of 32-bit bus words needed to carry n bits.
  function automatic int cdiv32(input int n);
    return (n + ADAPTER_WORD_W - 1) / ADAPTER_WORD_W;
  endfunction

  // Ceiling log2, never less than 1 so a single-word counter still has a bit.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) begin
      r = r + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/in_register.sv
// Reassembles a stream of 32-bit bus writes into one C_NUM_BITS-wide word,
// presented through a valid/ack hold stage with back-pressure and sticky overrun.
module in_register
  import adapter_pkg::*;
#(
  parameter int C_NUM_BITS = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [31:0]           din,
  input  logic                  we,
  input  logic                  clr,
  output logic                  full,
  output logic [C_NUM_BITS-1:0] dout,
  output logic                  dout_valid,
  input  logic                  dout_ack,
  output logic                  write,
  output logic                  ovf
);

  localparam int C_NUM_WORDS  = cdiv32(C_NUM_BITS);
  localparam int C_COUNT_BITS = clog2(C_NUM_WORDS);
  localparam int LAST_LOW     = ADAPTER_WORD_W * (C_NUM_WORDS - 1);
  localparam int LAST_BITS    = C_NUM_BITS - LAST_LOW;
  localparam logic [C_COUNT_BITS-1:0] LAST_IDX = C_COUNT_BITS'(C_NUM_WORDS - 1);

  logic [C_COUNT_BITS-1:0] count;
  logic                    last_word;
  logic                    accept;
  logic                    complete;
  logic [C_NUM_BITS-1:0]   assembled;

  // Only the final word can stall; earlier words never touch the hold stage.
  assign last_word = (count == LAST_IDX);
  assign full      = dout_valid & ~dout_ack & last_word;
  assign accept    = we & ~full & ~clr;
  assign complete  = accept & last_word;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (accept) begin
      if (last_word) begin
        count <= '0;
      end else begin
        count <= count + 1'b1;
      end
    end
  end

  generate
    if (C_NUM_WORDS == 1) begin : g_single
      assign assembled = din[C_NUM_BITS-1:0];
    end else begin : g_multi
      for (genvar k = 0; k < C_NUM_WORDS - 1; k++) begin : g_word
        logic [ADAPTER_WORD_W-1:0] word_q;

        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) begin
            word_q <= '0;
          end else if (accept && (count == C_COUNT_BITS'(k))) begin
            word_q <= din;
          end
        end

        assign assembled[ADAPTER_WORD_W*k +: ADAPTER_WORD_W] = word_q;
      end
      // Padding bits above C_NUM_BITS in the final bus word are simply dropped.
      assign assembled[C_NUM_BITS-1:LAST_LOW] = din[LAST_BITS-1:0];
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout       <= '0;
      dout_valid <= 1'b0;
      write      <= 1'b0;
    end else begin
      write <= complete;
      if (complete) begin
        dout       <= assembled;
        dout_valid <= 1'b1;
      end else if (dout_ack) begin
        dout_valid <= 1'b0;
      end
    end
  end

  // Restart clears the overrun record and outranks a simultaneous dropped write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf <= 1'b0;
    end else if (clr) begin
      ovf <= 1'b0;
    end else if (we && full) begin
      ovf <= 1'b1;
    end
  end

endmodule

// File: tb/tb_in_register.sv
// Self-checking bench for in_register: directed vector table on a 72-bit
// instance, reset sequences, and randomized traffic against a word-level model.
module tb_in_register;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;

  logic [31:0] a_din;
  logic        a_we, a_clr, a_ack;
  logic        a_full, a_valid, a_write, a_ovf;
  logic [71:0] a_dout;

  logic [31:0] b_din;
  logic        b_we, b_clr, b_ack;
  logic        b_full, b_valid, b_write, b_ovf;
  logic [31:0] b_dout;

  int checks   = 0;
  int failures = 0;

  in_register #(.C_NUM_BITS(72)) dut72 (
    .clk(clk), .rst_n(rst_n), .din(a_din), .we(a_we), .clr(a_clr),
    .full(a_full), .dout(a_dout), .dout_valid(a_valid), .dout_ack(a_ack),
    .write(a_write), .ovf(a_ovf)
  );

  in_register #(.C_NUM_BITS(32)) dut32 (
    .clk(clk), .rst_n(rst_n), .din(b_din), .we(b_we), .clr(b_clr),
    .full(b_full), .dout(b_dout), .dout_valid(b_valid), .dout_ack(b_ack),
    .write(b_write), .ovf(b_ovf)
  );

  typedef struct {
    logic        we;
    logic        clr;
    logic        ack;
    logic [31:0] din;
    logic        full;
    logic        valid;
    logic        wr;
    logic        ovf;
    logic [71:0] dout;
  } vec_t;

  typedef struct {
    logic [127:0] acc;
    int           cnt;
    logic [127:0] dout;
    logic         valid;
    logic         write;
    logic         ovf;
  } model_t;

  vec_t   vecs[$];
  model_t m72, m32;

  task automatic checkOutput(input string name, input logic [71:0] act, input logic [71:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mkVec(input logic we, input logic clr, input logic ack,
                                 input logic [31:0] din, input logic full, input logic valid,
                                 input logic wr, input logic ovf, input logic [71:0] dout);
    vec_t v;
    v.we = we; v.clr = clr; v.ack = ack; v.din = din;
    v.full = full; v.valid = valid; v.wr = wr; v.ovf = ovf; v.dout = dout;
    return v;
  endfunction

  task automatic idleInputs();
    a_we = 0; a_clr = 0; a_ack = 0; a_din = '0;
    b_we = 0; b_clr = 0; b_ack = 0; b_din = '0;
  endtask

  task automatic applyStimulus(input vec_t v, input int idx);
    @(negedge clk);
    a_we = v.we; a_clr = v.clr; a_ack = v.ack; a_din = v.din;
    #1;
    checkOutput($sformatf("vec%0d full", idx), {71'b0, a_full}, {71'b0, v.full});
    @(posedge clk);
    #1;
    checkOutput($sformatf("vec%0d dout", idx), a_dout, v.dout);
    checkOutput($sformatf("vec%0d valid", idx), {71'b0, a_valid}, {71'b0, v.valid});
    checkOutput($sformatf("vec%0d write", idx), {71'b0, a_write}, {71'b0, v.wr});
    checkOutput($sformatf("vec%0d ovf", idx), {71'b0, a_ovf}, {71'b0, v.ovf});
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, " a_dout"}, a_dout, 72'h0);
    checkOutput({tag, " a_valid"}, {71'b0, a_valid}, 72'h0);
    checkOutput({tag, " a_write"}, {71'b0, a_write}, 72'h0);
    checkOutput({tag, " a_full"}, {71'b0, a_full}, 72'h0);
    checkOutput({tag, " a_ovf"}, {71'b0, a_ovf}, 72'h0);
    checkOutput({tag, " b_dout"}, {40'b0, b_dout}, 72'h0);
    checkOutput({tag, " b_valid"}, {71'b0, b_valid}, 72'h0);
    checkOutput({tag, " b_ovf"}, {71'b0, b_ovf}, 72'h0);
  endtask

  task automatic modelReset(output model_t m);
    m.acc = '0; m.cnt = 0; m.dout = '0; m.valid = 0; m.write = 0; m.ovf = 0;
  endtask

  // Word-level behaviour: words accumulate by index; the last one completes.
  task automatic modelStep(input int nwords, input int nbits, input logic we, input logic clr,
                           input logic ack, input logic [31:0] din, inout model_t m,
                           output logic full_exp);
    logic done;
    done     = 1'b0;
    full_exp = m.valid && !ack && (m.cnt == nwords - 1);
    if (clr) begin
      m.cnt = 0;
      m.ovf = 1'b0;
    end else if (we && full_exp) begin
      m.ovf = 1'b1;
    end else if (we) begin
      m.acc[32*m.cnt +: 32] = din;
      m.cnt = m.cnt + 1;
      if (m.cnt == nwords) begin
        m.cnt  = 0;
        m.dout = m.acc & ((128'd1 << nbits) - 128'd1);
        done   = 1'b1;
      end
    end
    m.write = done;
    if (done) m.valid = 1'b1;
    else if (ack) m.valid = 1'b0;
  endtask

  initial begin
    logic ef72, ef32;
    logic [71:0] d1, d2, d3, d4, d5;

    idleInputs();
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #3;
    checkAllZero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    d1 = 72'hAB_22222222_11111111;
    d2 = 72'h55_44444444_33333333;
    d3 = 72'h88_77777777_66666666;
    d4 = 72'h0C_05060708_01020304;
    d5 = 72'hC1_B0B0B0B0_A0A0A0A0;
    //                 we clr ack din          full vld wr ovf dout
    vecs.push_back(mkVec(1, 0, 0, 32'h11111111, 0, 0, 0, 0, 72'h0));
    vecs.push_back(mkVec(1, 0, 0, 32'h22222222, 0, 0, 0, 0, 72'h0));
    vecs.push_back(mkVec(1, 0, 0, 32'hFFFFFFAB, 0, 1, 1, 0, d1));
    vecs.push_back(mkVec(0, 0, 0, 32'h0,        0, 1, 0, 0, d1));
    vecs.push_back(mkVec(1, 0, 0, 32'h33333333, 0, 1, 0, 0, d1));
    vecs.push_back(mkVec(1, 0, 0, 32'h44444444, 0, 1, 0, 0, d1));
    vecs.push_back(mkVec(1, 0, 0, 32'h55555555, 1, 1, 0, 1, d1));
    vecs.push_back(mkVec(0, 0, 1, 32'h0,        0, 0, 0, 1, d1));
    vecs.push_back(mkVec(1, 0, 0, 32'h55555555, 0, 1, 1, 1, d2));
    vecs.push_back(mkVec(1, 0, 0, 32'h66666666, 0, 1, 0, 1, d2));
    vecs.push_back(mkVec(1, 0, 0, 32'h77777777, 0, 1, 0, 1, d2));
    vecs.push_back(mkVec(1, 0, 1, 32'h88888888, 0, 1, 1, 1, d3));
    vecs.push_back(mkVec(1, 0, 0, 32'h99999999, 0, 1, 0, 1, d3));
    vecs.push_back(mkVec(1, 1, 0, 32'hAAAAAAAA, 0, 1, 0, 0, d3));
    vecs.push_back(mkVec(1, 0, 0, 32'h01020304, 0, 1, 0, 0, d3));
    vecs.push_back(mkVec(1, 0, 0, 32'h05060708, 0, 1, 0, 0, d3));
    vecs.push_back(mkVec(1, 0, 1, 32'h090A0B0C, 0, 1, 1, 0, d4));
    vecs.push_back(mkVec(0, 0, 1, 32'h0,        0, 0, 0, 0, d4));
    vecs.push_back(mkVec(0, 0, 1, 32'h0,        0, 0, 0, 0, d4));
    vecs.push_back(mkVec(1, 0, 0, 32'hA0A0A0A0, 0, 0, 0, 0, d4));
    vecs.push_back(mkVec(1, 0, 0, 32'hB0B0B0B0, 0, 0, 0, 0, d4));
    vecs.push_back(mkVec(1, 0, 0, 32'hC0C0C0C1, 0, 1, 1, 0, d5));
    vecs.push_back(mkVec(1, 0, 0, 32'hD0D0D0D0, 0, 1, 0, 0, d5));
    vecs.push_back(mkVec(1, 0, 0, 32'hE0E0E0E0, 0, 1, 0, 0, d5));
    vecs.push_back(mkVec(1, 1, 0, 32'hF0F0F0F0, 1, 1, 0, 0, d5));
    vecs.push_back(mkVec(1, 0, 0, 32'h12345678, 0, 1, 0, 0, d5));
    vecs.push_back(mkVec(1, 0, 0, 32'h13131313, 0, 1, 0, 0, d5));

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i], i);
    end

    // Two words are pending; an async reset must wipe everything without a clock.
    @(negedge clk);
    idleInputs();
    rst_n = 1'b0;
    #1;
    checkAllZero("midreset");
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(mkVec(1, 0, 0, 32'h00000001, 0, 0, 0, 0, 72'h0), 100);
    applyStimulus(mkVec(1, 0, 0, 32'h00000002, 0, 0, 0, 0, 72'h0), 101);
    applyStimulus(mkVec(1, 0, 0, 32'h000000F3, 0, 1, 1, 0, 72'hF3_00000002_00000001), 102);

    // Single-word instance: every accepted write completes immediately.
    @(negedge clk);
    idleInputs();
    b_we = 1; b_din = 32'hDEADBEEF;
    @(posedge clk);
    #1;
    checkOutput("w32 dout", {40'b0, b_dout}, {40'b0, 32'hDEADBEEF});
    checkOutput("w32 write", {71'b0, b_write}, {71'b0, 1'b1});
    checkOutput("w32 valid", {71'b0, b_valid}, {71'b0, 1'b1});

    @(negedge clk);
    idleInputs();
    rst_n = 1'b0;
    modelReset(m72);
    modelReset(m32);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      a_we  = ($urandom_range(0, 3) != 0);
      a_clr = ($urandom_range(0, 19) == 0);
      a_ack = ($urandom_range(0, 2) == 0);
      a_din = $urandom;
      b_we  = ($urandom_range(0, 2) != 0);
      b_clr = ($urandom_range(0, 19) == 0);
      b_ack = ($urandom_range(0, 2) == 0);
      b_din = $urandom;
      #1;
      modelStep(3, 72, a_we, a_clr, a_ack, a_din, m72, ef72);
      modelStep(1, 32, b_we, b_clr, b_ack, b_din, m32, ef32);
      checkOutput("rand72 full", {71'b0, a_full}, {71'b0, ef72});
      checkOutput("rand32 full", {71'b0, b_full}, {71'b0, ef32});
      @(posedge clk);
      #1;
      checkOutput("rand72 dout", a_dout, m72.dout[71:0]);
      checkOutput("rand72 valid", {71'b0, a_valid}, {71'b0, m72.valid});
      checkOutput("rand72 write", {71'b0, a_write}, {71'b0, m72.write});
      checkOutput("rand72 ovf", {71'b0, a_ovf}, {71'b0, m72.ovf});
      checkOutput("rand32 dout", {40'b0, b_dout}, {40'b0, m32.dout[31:0]});
      checkOutput("rand32 valid", {71'b0, b_valid}, {71'b0, m32.valid});
      checkOutput("rand32 write", {71'b0, b_write}, {71'b0, m32.write});
      checkOutput("rand32 ovf", {71'b0, b_ovf}, {71'b0, m32.ovf});
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
